// File: rtl/kf8288_pkg.sv
// kf8288_pkg
//   Shared definitions for the 8288-style bus controller family:
//   CPU status encodings (S2..S0), T-state and cycle-type enumerations,
//   and small classification helpers used by the command decoder.
package kf8288_pkg;

   localparam logic [2:0] STATUS_INTA    = 3'b000;
   localparam logic [2:0] STATUS_IOR     = 3'b001;
   localparam logic [2:0] STATUS_IOW     = 3'b010;
   localparam logic [2:0] STATUS_HALT    = 3'b011;
   localparam logic [2:0] STATUS_CODE    = 3'b100;
   localparam logic [2:0] STATUS_MEMR    = 3'b101;
   localparam logic [2:0] STATUS_MEMW    = 3'b110;
   localparam logic [2:0] STATUS_PASSIVE = 3'b111;

   typedef enum logic [2:0] {
      TS_TI = 3'd0,
      TS_T1 = 3'd1,
      TS_T2 = 3'd2,
      TS_T3 = 3'd3,
      TS_TW = 3'd4,
      TS_T4 = 3'd5
   } t_state_e;

   // Cycle types share the status encoding so a latched status casts directly.
   typedef enum logic [2:0] {
      CYC_INTA = 3'b000,
      CYC_IOR  = 3'b001,
      CYC_IOW  = 3'b010,
      CYC_HALT = 3'b011,
      CYC_CODE = 3'b100,
      CYC_MEMR = 3'b101,
      CYC_MEMW = 3'b110
   } cycle_type_e;

   // Cycles where data flows towards the CPU (DT/R# low, DEN ends with T3/TW).
   function automatic logic is_read_cycle(input cycle_type_e cycle);
      return (cycle == CYC_INTA) || (cycle == CYC_IOR) ||
             (cycle == CYC_CODE) || (cycle == CYC_MEMR);
   endfunction

endpackage

// File: rtl/kf8288_clock_edge.sv
// kf8288_clock_edge
//   Detects edges of a slower clock-like signal sampled on the fast clock.
//   Ports:
//     clock   - fast sampling clock
//     reset   - asynchronous active-high reset (previous level forced low)
//     sample  - slow signal being watched (e.g. cpu_clock)
//     rising  - high for the one fast-clock cycle where sample went 0->1
//     falling - high for the one fast-clock cycle where sample went 1->0
module kf8288_clock_edge (
   input  logic clock,
   input  logic reset,
   input  logic sample,
   output logic rising,
   output logic falling
);

   logic prev_level;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_level <= 1'b0;
      end else begin
         prev_level <= sample;
      end
   end

   assign rising  = sample & ~prev_level;
   assign falling = ~sample & prev_level;

endmodule

// File: rtl/kf8288_wait_bus_controller.sv
// kf8288_wait_bus_controller
//   8288-style bus command generator with programmable wait states.
//   Tracks the CPU T-states (TI, T1, T2, T3, TW, T4) from the S2..S0 status,
//   advancing only on cpu_clock falling edges seen on the fast system clock.
//   Ports:
//     clock, reset                    - system clock, async active-high reset
//     cpu_clock                       - CPU clock, sampled on clock
//     processor_status                - S2..S0 (111 = passive)
//     ready                           - external bus ready (synchronous to clock)
//     address_enable_n, command_enable, io_bus_mode - command gating controls
//     cpu_ready                       - ready back to the CPU
//     address_latch_enable, data_enable, direction_transmit_or_receive_n
//     *_command_n, interrupt_acknowledge_n - active-low bus commands
//     halt_detected, bus_cycle_done   - single-clock event pulses
module kf8288_wait_bus_controller
   import kf8288_pkg::*;
#(
   parameter int WAIT_WIDTH = 3,
   parameter int MEM_WAIT   = 0,
   parameter int IO_WAIT    = 1,
   parameter int INTA_WAIT  = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cpu_clock,
   input  logic [2:0] processor_status,
   input  logic       ready,
   input  logic       address_enable_n,
   input  logic       command_enable,
   input  logic       io_bus_mode,
   output logic       cpu_ready,
   output logic       address_latch_enable,
   output logic       data_enable,
   output logic       direction_transmit_or_receive_n,
   output logic       memory_read_command_n,
   output logic       memory_write_command_n,
   output logic       advanced_memory_write_command_n,
   output logic       io_read_command_n,
   output logic       io_write_command_n,
   output logic       advanced_io_write_command_n,
   output logic       interrupt_acknowledge_n,
   output logic       halt_detected,
   output logic       bus_cycle_done
);

   localparam logic [2:0] ST_TI = TS_TI;
   localparam logic [2:0] ST_T1 = TS_T1;
   localparam logic [2:0] ST_T2 = TS_T2;
   localparam logic [2:0] ST_T3 = TS_T3;
   localparam logic [2:0] ST_TW = TS_TW;
   localparam logic [2:0] ST_T4 = TS_T4;

   logic                  cpu_clock_negedge;
   logic [2:0]            state;
   cycle_type_e           cycle_type;
   logic [WAIT_WIDTH-1:0] wait_count;
   logic                  status_passive;
   logic                  status_halt;
   logic                  start_cycle;
   logic                  wait_pending;
   logic                  read_cycle;
   logic                  early_window;
   logic                  late_window;
   logic                  mem_gate;
   logic                  io_gate;

   function automatic logic [WAIT_WIDTH-1:0] wait_load(input logic [2:0] status);
      logic [WAIT_WIDTH-1:0] count;
      case (status)
         STATUS_CODE, STATUS_MEMR, STATUS_MEMW: count = WAIT_WIDTH'(MEM_WAIT);
         STATUS_IOR, STATUS_IOW:                count = WAIT_WIDTH'(IO_WAIT);
         STATUS_INTA:                           count = WAIT_WIDTH'(INTA_WAIT);
         default:                               count = '0;
      endcase
      return count;
   endfunction

   kf8288_clock_edge u_cpu_clock_edge (
      .clock   (clock),
      .reset   (reset),
      .sample  (cpu_clock),
      .rising  (),
      .falling (cpu_clock_negedge)
   );

   assign status_passive = (processor_status == STATUS_PASSIVE);
   assign status_halt    = (processor_status == STATUS_HALT);
   // Halt is acknowledged but never opens a bus cycle.
   assign start_cycle    = !status_passive && !status_halt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= ST_TI;
         cycle_type     <= CYC_HALT;
         wait_count     <= '0;
         halt_detected  <= 1'b0;
         bus_cycle_done <= 1'b0;
      end else begin
         halt_detected  <= 1'b0;
         bus_cycle_done <= 1'b0;
         if (cpu_clock_negedge) begin
            case (state)
               // T4 behaves like TI for starting the next cycle, so a status
               // already present at the end of T4 runs back-to-back.
               ST_TI, ST_T4: begin
                  if (state == ST_T4) begin
                     bus_cycle_done <= 1'b1;
                  end
                  if (start_cycle) begin
                     state      <= ST_T1;
                     cycle_type <= cycle_type_e'(processor_status);
                     wait_count <= wait_load(processor_status);
                  end else begin
                     state <= ST_TI;
                     if (status_halt) begin
                        halt_detected <= 1'b1;
                     end
                  end
               end
               ST_T1: state <= ST_T2;
               ST_T2: state <= ST_T3;
               ST_T3, ST_TW: begin
                  if (wait_pending) begin
                     state <= ST_TW;
                  end else begin
                     state <= ST_T4;
                  end
                  if (wait_count != '0) begin
                     wait_count <= wait_count - WAIT_WIDTH'(1);
                  end
               end
               default: state <= ST_TI;
            endcase
         end
      end
   end

   // Outputs decode the current T-state directly so an asynchronous reset
   // drops every command in the same clock.
   always_comb begin
      wait_pending = (wait_count != '0) || !ready;
      read_cycle   = is_read_cycle(cycle_type);
      early_window = (state == ST_T2) || (state == ST_T3) || (state == ST_TW);
      late_window  = (state == ST_T3) || (state == ST_TW);
      mem_gate     = command_enable && !address_enable_n;
      // In IOB mode the IO commands belong to a private bus that AEN does not own.
      io_gate      = command_enable && (!address_enable_n || io_bus_mode);

      address_latch_enable            = (state == ST_T1) && !status_passive;
      cpu_ready                       = !(early_window && wait_pending);
      direction_transmit_or_receive_n = !((state != ST_TI) && read_cycle);
      data_enable                     = read_cycle ? early_window
                                                   : (early_window || (state == ST_T4));

      memory_read_command_n           = !(early_window && mem_gate &&
                                          ((cycle_type == CYC_MEMR) || (cycle_type == CYC_CODE)));
      advanced_memory_write_command_n = !(early_window && mem_gate && (cycle_type == CYC_MEMW));
      memory_write_command_n          = !(late_window  && mem_gate && (cycle_type == CYC_MEMW));
      io_read_command_n               = !(early_window && io_gate  && (cycle_type == CYC_IOR));
      advanced_io_write_command_n     = !(early_window && io_gate  && (cycle_type == CYC_IOW));
      io_write_command_n              = !(late_window  && io_gate  && (cycle_type == CYC_IOW));
      interrupt_acknowledge_n         = !(early_window && mem_gate && (cycle_type == CYC_INTA));
   end

endmodule
